view_scan_ctrl: RTL and testbench

- Frame sequencer for the view-ray datapath.
- On start, latches the camera config (view normal, view distance) so mid-frame changes do not apply.
- Walks every screen location (x, y) in raster order and drives each onto the ray datapath's view_loc input.
- Waits the datapath's fixed latency, captures the resulting ray, and hands it to the downstream tracer over a valid/ready handshake.
- Sits between the camera-config registers and the tracer core; it is the only master of the ray datapath.

---
 rtl/view_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_view_scan_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/view_scan_ctrl.sv
// view_scan_ctrl: frame sequencer for the view-ray datapath.
// Latches the camera config on start, walks every (x, y) screen location in
// raster order onto the datapath, waits the datapath latency, captures the
// resulting ray and offers it downstream over a valid/ready handshake.
// Optional feature macro: VIEW_SCAN_ABORT_EN (adds the 'abort' input).
module view_scan_ctrl #(
  parameter int unsigned RAY_LAT = 4,   // cycles from ray_loc change to ray_in valid (>= 1)
  parameter int unsigned X_MAX   = 127, // last x index (<= 127)
  parameter int unsigned Y_MAX   = 63   // last y index (<= 63)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] cam_normal,
  input  logic [9:0]  cam_dist,
`ifdef VIEW_SCAN_ABORT_EN
  input  logic        abort,
`endif
  output logic [27:0] ray_normal,
  output logic [9:0]  ray_dist,
  output logic [12:0] ray_loc,
  input  logic [27:0] ray_in,
  output logic        ray_valid,
  input  logic        ray_ready,
  output logic [27:0] ray_data,
  output logic [12:0] ray_pix,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LW = (RAY_LAT > 1) ? $clog2(RAY_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(RAY_LAT - 1);
  localparam logic [6:0]    X_LAST   = 7'(X_MAX);
  localparam logic [5:0]    Y_LAST   = 6'(Y_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    x_q, x_d;
  logic [5:0]    y_q, y_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [12:0]   loc_q, loc_d;
  logic [27:0]   data_q, data_d;
  logic [12:0]   pix_q, pix_d;
  logic          valid_q, valid_d;
  logic [27:0]   normal_q, normal_d;
  logic [9:0]    dist_q, dist_d;

  logic          abort_w;
  logic          last_pix;
  logic [6:0]    x_nx;
  logic [5:0]    y_nx;

`ifdef VIEW_SCAN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // Raster-order successor of the current pixel
  always_comb begin
    x_nx = x_q + 7'd1;
    y_nx = y_q;
    if (x_q == X_LAST) begin
      x_nx = '0;
      y_nx = y_q + 6'd1;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    lat_d    = lat_q;
    loc_d    = loc_q;
    data_d   = data_q;
    pix_d    = pix_q;
    valid_d  = valid_q;
    normal_d = normal_q;
    dist_d   = dist_q;

    case (state_q)
      IDLE: begin
        if (start && !abort_w) begin
          normal_d = cam_normal;
          dist_d   = cam_dist;
          x_d      = '0;
          y_d      = '0;
          // ray_loc is updated on entry to ISSUE so the datapath latency
          // starts counting from the first cycle of ISSUE.
          loc_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          data_d  = ray_in;
          pix_d   = {y_q, x_q};
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (ray_ready) begin
          valid_d = 1'b0;
          if (last_pix) begin
            state_d = DONE;
          end else begin
            x_d     = x_nx;
            y_d     = y_nx;
            loc_d   = {y_nx, x_nx};
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Abort overrides everything, including a simultaneous handshake
    if (abort_w && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      lat_d   = '0;
      loc_d   = loc_q;
      data_d  = data_q;
      pix_d   = pix_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      lat_q    <= '0;
      loc_q    <= '0;
      data_q   <= '0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      normal_q <= '0;
      dist_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lat_q    <= lat_d;
      loc_q    <= loc_d;
      data_q   <= data_d;
      pix_q    <= pix_d;
      valid_q  <= valid_d;
      normal_q <= normal_d;
      dist_q   <= dist_d;
    end
  end

  assign ray_normal = normal_q;
  assign ray_dist   = dist_q;
  assign ray_loc    = loc_q;
  assign ray_valid  = valid_q;
  assign ray_data   = data_q;
  assign ray_pix    = pix_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_view_scan_ctrl.sv
// Testbench for view_scan_ctrl: small 4x2 frame, datapath modelled as a
// 4-stage echo of ray_loc. A cycle-level reference model built from the frame
// rules (pixel list queue, per-pixel latency countdown) is checked every cycle.
module tb_view_scan_ctrl;

  localparam int unsigned XM  = 3;
  localparam int unsigned YM  = 1;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] cam_normal;
  logic [9:0]  cam_dist;
  logic        abort;
  logic [27:0] ray_normal;
  logic [9:0]  ray_dist;
  logic [12:0] ray_loc;
  logic [27:0] ray_in;
  logic        ray_valid;
  logic        ray_ready;
  logic [27:0] ray_data;
  logic [12:0] ray_pix;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  view_scan_ctrl #(
    .RAY_LAT(LAT),
    .X_MAX  (XM),
    .Y_MAX  (YM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cam_normal(cam_normal),
    .cam_dist  (cam_dist),
`ifdef VIEW_SCAN_ABORT_EN
    .abort     (abort),
`endif
    .ray_normal(ray_normal),
    .ray_dist  (ray_dist),
    .ray_loc   (ray_loc),
    .ray_in    (ray_in),
    .ray_valid (ray_valid),
    .ray_ready (ray_ready),
    .ray_data  (ray_data),
    .ray_pix   (ray_pix),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Datapath stand-in: ray_loc echoed after exactly four clock edges
  logic [12:0] d0, d1, d2, d3;
  always_ff @(posedge clk) begin
    d0 <= ray_loc;
    d1 <= d0;
    d2 <= d1;
    d3 <= d2;
  end
  assign ray_in = {15'd0, d3};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  bit          m_busy, m_valid, m_done;
  int          m_wait;
  logic [12:0] exp_q[$];
  logic [27:0] m_norm;
  logic [9:0]  m_dist;

  task automatic model_reset();
    m_busy  = 0;
    m_valid = 0;
    m_done  = 0;
    m_wait  = 0;
    exp_q.delete();
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic model_step();
    if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1;
        m_norm = cam_normal;
        m_dist = cam_dist;
        exp_q.delete();
        for (int unsigned yy = 0; yy <= YM; yy++)
          for (int unsigned xx = 0; xx <= XM; xx++)
            exp_q.push_back(13'((yy << 7) | xx));
        m_wait  = LAT + 1;
        m_valid = 0;
        m_done  = 0;
      end
    end else if (abort) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_valid) begin
      if (ray_ready) begin
        void'(exp_q.pop_front());
        m_valid = 0;
        if (exp_q.size() == 0) m_done = 1;
        else m_wait = LAT + 1;
      end
    end else begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_busy);
    chk("ray_valid", ray_valid, m_valid);
    chk("frame_done", frame_done, m_done);
    if (m_busy) begin
      chk("ray_normal", ray_normal, m_norm);
      chk("ray_dist", ray_dist, m_dist);
    end
    if (m_busy && !m_done && exp_q.size() > 0)
      chk("ray_loc", ray_loc, exp_q[0]);
    if (m_valid && exp_q.size() > 0) begin
      chk("ray_pix", ray_pix, exp_q[0]);
      chk("ray_data", ray_data, {15'd0, exp_q[0]});
    end
  endtask

  // One clock cycle: model follows the edge, outputs compared 1 time unit later
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_zeros(input string tag);
    chk({tag, "_valid"}, ray_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_loc"}, ray_loc, 0);
    chk({tag, "_data"}, ray_data, 0);
    chk({tag, "_pix"}, ray_pix, 0);
    chk({tag, "_normal"}, ray_normal, 0);
    chk({tag, "_dist"}, ray_dist, 0);
  endtask

  task automatic do_reset(input string tag);
    start     = 0;
    ray_ready = 1;
    abort     = 0;
    rst_n     = 0;
    model_reset();
    #2;
    check_zeros(tag);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit          hold;       // keep start high for the whole run
    int          stall_from; // first cycle with ray_ready low (-1: never)
    int          stall_len;
    int          ncyc;
    int          exp_hs;     // handshakes expected within ncyc cycles
    int          exp_fd;     // frame_done pulses expected
    logic [27:0] nrm;
    logic [9:0]  dst;
  } vec_t;

  vec_t vt[3];

  initial begin
    int hs, fd;

    vt[0] = '{hold: 0, stall_from: -1, stall_len: 0,  ncyc: 60,  exp_hs: 8,  exp_fd: 1, nrm: 28'h1234567, dst: 10'h155};
    vt[1] = '{hold: 0, stall_from: 10, stall_len: 10, ncyc: 70,  exp_hs: 8,  exp_fd: 1, nrm: 28'hABCDEF0, dst: 10'h2AA};
    vt[2] = '{hold: 1, stall_from: -1, stall_len: 0,  ncyc: 150, exp_hs: 24, exp_fd: 3, nrm: 28'hFFFFFFF, dst: 10'h3FF};

    rst_n      = 0;
    start      = 0;
    abort      = 0;
    ray_ready  = 1;
    cam_normal = '0;
    cam_dist   = '0;
    model_reset();
    #12;
    check_zeros("por");
    @(posedge clk);
    #1;
    rst_n = 1;

    // Table-driven frame scenarios
    for (int v = 0; v < 3; v++) begin
      do_reset("rst_tbl");
      hs         = 0;
      fd         = 0;
      start      = 1;
      ray_ready  = 1;
      cam_normal = vt[v].nrm;
      cam_dist   = vt[v].dst;
      for (int i = 1; i <= vt[v].ncyc; i++) begin
        cyc();
        if (!vt[v].hold) start = 0;
        if (i == 20) begin
          cam_normal = '0;
          cam_dist   = '0;
        end
        ray_ready = !(vt[v].stall_from >= 0 && i >= vt[v].stall_from &&
                      i < vt[v].stall_from + vt[v].stall_len);
        if (ray_valid && ray_ready) hs++;
        if (frame_done) fd++;
      end
      chk("hs_count", hs, vt[v].exp_hs);
      chk("fd_count", fd, vt[v].exp_fd);
    end

    // Reset during WAIT of pixel 5, then restart from pixel 0
    do_reset("rst_pre5");
    start      = 1;
    cam_normal = 28'h1234567;
    cam_dist   = 10'h155;
    for (int i = 1; i <= 27; i++) begin
      cyc();
      start = 0;
    end
    chk("mid_busy", busy, 1);
    chk("mid_loc", ray_loc, 13'h080);
    rst_n = 0;
    model_reset();
    #2;
    check_zeros("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    fd = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (frame_done) fd++;
    end
    chk("no_fd_after_rst", fd, 0);
    start = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      start = 0;
    end
    chk("restart_valid", ray_valid, 1);
    chk("restart_pix", ray_pix, 13'h000);

`ifdef VIEW_SCAN_ABORT_EN
    // Abort during OUT of pixel 3 with a simultaneous handshake
    do_reset("rst_abort");
    start = 1;
    for (int i = 1; i <= 18; i++) begin
      cyc();
      start = 0;
    end
    chk("ab_valid_pre", ray_valid, 1);
    chk("ab_pix_pre", ray_pix, 13'h002);
    ray_ready = 1;
    abort     = 1;
    cyc();
    chk("ab_busy", busy, 0);
    chk("ab_valid", ray_valid, 0);
    chk("ab_done", frame_done, 0);
    start = 1;
    cyc();
    chk("ab_start_blocked", busy, 0);
    abort = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      start = 0;
    end
    chk("ab_restart_pix", ray_pix, 13'h000);
    chk("ab_restart_valid", ray_valid, 1);
`endif

    // Randomized stimulus against the reference model
    do_reset("rst_rand");
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      ray_ready  = ($urandom_range(0, 2) != 0);
      cam_normal = 28'($urandom);
      cam_dist   = 10'($urandom);
`ifdef VIEW_SCAN_ABORT_EN
      abort      = ($urandom_range(0, 59) == 0);
`endif
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
